multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Multicycle control sequencer that drives the 3-bit `state` bus and the `pc_write`/`pc_src` controls consumed by the PC register. It also generates the memory, IR and register-file strobes. It steps each instruction through IF/ID/EX/MEM/WB, stalls on memory handshakes, and counts cycles and retired instructions.

Parameters:
CNT_W, 32, width of cycle and retired-instruction counters (wrap modulo 2^CNT_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_class  in  3  decoded class of IR: 0 ALU_R, 1 ALU_I, 2 LOAD, 3 STORE, 4 BRANCH, 5 JUMP, 6 HALT, 7 illegal
alu_zero  in  1  ALU zero flag, valid in EX
mem_ready  in  1  memory handshake: access completes in the cycle it is high
state  out  3  current state: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB, 5 HALT, 7 INIT (6 unused)
pc_write  out  1  PC load strobe
pc_src  out  2  0 PC+4, 1 branch target, 2 jump target
ir_write  out  1  IR load strobe
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  0 = address from PC, 1 = address from ALU result
reg_write  out  1  register-file write strobe
mem_to_reg  out  1  WB data source: 1 memory, 0 ALU
illegal  out  1  sticky flag for illegal class
halted  out  1  high while in HALT
cycle_cnt  out  CNT_W  active cycles
instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async, rst_n=0):
  - state=INIT(7), class_q=0.
  - illegal=0, cycle_cnt=0, instr_cnt=0.
  - All strobes 0, pc_src=0, iord=0, mem_to_reg=0, halted=0.
- State register is the only sequential control; all strobes are combinational from state, class_q, alu_zero and mem_ready.
- State sequence:
  - INIT: all strobes 0; next state IF unconditionally.
  - IF:
    - mem_read=1, iord=0.
    - mem_ready=0: stay in IF, ir_write=0, pc_write=0.
    - mem_ready=1: ir_write=1, pc_write=1, pc_src=0, go to ID.
  - ID: class_q <= instr_class.
    - JUMP: pc_write=1, pc_src=2, retire, go to IF.
    - HALT: go to HALT.
    - Class 7: set illegal, go to HALT.
    - Otherwise: go to EX.
  - EX, by class_q:
    - ALU_R or ALU_I: go to WB.
    - LOAD or STORE: go to MEM.
    - BRANCH: pc_write=alu_zero, pc_src=1, retire, go to IF. The branch retires whether or not it is taken.
  - MEM: iord=1.
    - mem_read=1 for LOAD; mem_write=1 for STORE.
    - The request is held every cycle while mem_ready=0.
    - On mem_ready=1: LOAD goes to WB; STORE retires and goes to IF.
  - WB: reg_write=1, mem_to_reg=(class_q==LOAD), retire, go to IF.
  - HALT: halted=1, all other strobes 0, stay. Only reset exits HALT.
  - State 6 (unreachable): treated as HALT, with illegal set.
- Retire: instr_cnt increments on the clock edge that leaves the retiring state.
- cycle_cnt increments every cycle the state is not INIT or HALT, including stall cycles.
- Both counters wrap with no saturation.
- Latency per instruction with zero wait states:
  - ALU: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
  - JUMP: 2 cycles.
  - Each cycle mem_ready=0 in IF or MEM adds one cycle.
- Boundaries:
  - instr_class changes after ID are ignored because class_q is latched.
  - mem_ready is ignored outside IF and MEM.
  - Reset asserted mid-MEM drops mem_write/mem_read in the same cycle (asynchronous).
  - pc_write is never asserted in INIT, MEM or HALT.

Test Plan:
- Reset release, mem_ready=1, ALU_R stream -> state 7,0,1,2,4,0...; pc_write high in IF only; instr_cnt=3 after 13 cycles; cycle_cnt=12.
- LOAD with mem_ready held low 3 cycles in MEM -> mem_read/iord=1 held 4 cycles; WB with reg_write=1 and mem_to_reg=1; 8 cycles total.
- BRANCH with alu_zero=1 and then alu_zero=0 -> pc_write=1, pc_src=1 in EX for the first; pc_write=0 for the second; instr_cnt increments both times.
- JUMP -> pc_write in IF (pc_src=0) and again in ID (pc_src=2); back to IF after 2 cycles.
- instr_class=7 in ID -> illegal=1, halted=1, state=5 persists 20 cycles, counters frozen; rst_n pulse clears all.
- rst_n=0 asynchronously during STORE MEM wait -> mem_write drops immediately; state=7 and counters=0 before the next clk edge.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control sequencer: steps each instruction through IF/ID/EX/MEM/WB and drives PC, IR, memory and register-file strobes.
// Latency: strobes are combinational from the current state; state and counters update on each rising clk edge.
// Backpressure: mem_ready=0 holds the sequencer in IF or MEM with the memory request asserted.
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   instr_class         - decoded IR class, sampled and latched in ID
//   alu_zero            - ALU zero flag, used by BRANCH in EX
//   mem_ready           - memory completes the access in the cycle it is high
//   state               - current state code (0 IF .. 5 HALT, 7 INIT)
//   pc_write, pc_src    - PC load strobe and source select (0 PC+4, 1 branch, 2 jump)
//   ir_write            - IR load strobe
//   mem_read, mem_write - memory requests; iord selects PC (0) or ALU result (1) as address
//   reg_write           - register-file write; mem_to_reg selects memory data for WB
//   illegal             - sticky illegal-class flag; halted is high in HALT
//   cycle_cnt           - active cycles (excludes INIT and HALT)
//   instr_cnt           - retired instructions
module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       instr_class,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_BAD  = 3'd6,
        S_INIT = 3'd7
    } state_t;

    localparam logic [2:0] CL_ALU_R  = 3'd0;
    localparam logic [2:0] CL_ALU_I  = 3'd1;
    localparam logic [2:0] CL_LOAD   = 3'd2;
    localparam logic [2:0] CL_STORE  = 3'd3;
    localparam logic [2:0] CL_BRANCH = 3'd4;
    localparam logic [2:0] CL_JUMP   = 3'd5;
    localparam logic [2:0] CL_HALT   = 3'd6;
    localparam logic [2:0] CL_ILL    = 3'd7;

    state_t           state_q, state_d;
    logic [2:0]       class_q, class_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;
    logic             retire;
    logic             active;

    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        illegal_d  = illegal_q;
        retire     = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_INIT: state_d = S_IF;
            S_IF: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end
            end
            S_ID: begin
                // class_q is not yet valid here, so decode the live input.
                class_d = instr_class;
                case (instr_class)
                    CL_JUMP: begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                        retire   = 1'b1;
                        state_d  = S_IF;
                    end
                    CL_HALT: state_d = S_HALT;
                    CL_ILL: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                    default: state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (class_q)
                    CL_ALU_R, CL_ALU_I: state_d = S_WB;
                    CL_LOAD, CL_STORE:  state_d = S_MEM;
                    CL_BRANCH: begin
                        // Taken or not, the branch is finished here.
                        pc_write = alu_zero;
                        pc_src   = 2'd1;
                        retire   = 1'b1;
                        state_d  = S_IF;
                    end
                    default: begin
                        // JUMP/HALT/illegal never reach EX; park defensively.
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                iord      = 1'b1;
                mem_read  = (class_q == CL_LOAD);
                mem_write = (class_q == CL_STORE);
                if (mem_ready) begin
                    if (class_q == CL_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (class_q == CL_LOAD);
                retire     = 1'b1;
                state_d    = S_IF;
            end
            S_HALT: halted = 1'b1;
            default: begin
                // Unreachable code 6: behave as HALT and flag it.
                halted    = 1'b1;
                illegal_d = 1'b1;
                state_d   = S_HALT;
            end
        endcase
    end

    assign active = (state_q != S_INIT) && (state_q != S_HALT) && (state_q != S_BAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            class_q     <= 3'd0;
            illegal_q   <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            illegal_q <= illegal_d;
            if (active) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            if (retire) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
        end
    end

    assign state     = state_q;
    assign illegal   = illegal_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic [2:0]  instr_class;
    logic        alu_zero;
    logic        mem_ready;
    logic [2:0]  state;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        reg_write;
    logic        mem_to_reg;
    logic        illegal;
    logic        halted;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    multicycle_ctrl_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr_class(instr_class), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .state(state), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .halted(halted), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle: {pc_write, pc_src[1:0], ir_write, mem_read, mem_write,
    //                  iord, reg_write, mem_to_reg, halted, illegal}
    localparam logic [10:0] C_NONE = 11'b0_00_0_0_0_0_0_0_0_0;
    localparam logic [10:0] C_IF   = 11'b1_00_1_1_0_0_0_0_0_0;
    localparam logic [10:0] C_IFS  = 11'b0_00_0_1_0_0_0_0_0_0;
    localparam logic [10:0] C_WBA  = 11'b0_00_0_0_0_0_1_0_0_0;
    localparam logic [10:0] C_WBL  = 11'b0_00_0_0_0_0_1_1_0_0;
    localparam logic [10:0] C_MRD  = 11'b0_00_0_1_0_1_0_0_0_0;
    localparam logic [10:0] C_MWR  = 11'b0_00_0_0_1_1_0_0_0_0;
    localparam logic [10:0] C_BRT  = 11'b1_01_0_0_0_0_0_0_0_0;
    localparam logic [10:0] C_BRN  = 11'b0_01_0_0_0_0_0_0_0_0;
    localparam logic [10:0] C_JMP  = 11'b1_10_0_0_0_0_0_0_0_0;

    typedef struct {
        logic [2:0]  cls;
        logic        az;
        logic        rdy;
        logic [2:0]  st;
        logic [10:0] ctl;
        logic [31:0] cyc;
        logic [31:0] inst;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [10:0] ctl_now();
        return {pc_write, pc_src, ir_write, mem_read, mem_write, iord,
                reg_write, mem_to_reg, halted, illegal};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] cls, input logic az, input logic rdy,
                       input logic [2:0] st, input logic [10:0] ctl,
                       input int cyc, input int inst);
        vec_t v;
        v.cls = cls; v.az = az; v.rdy = rdy; v.st = st; v.ctl = ctl;
        v.cyc = cyc; v.inst = inst;
        vecs.push_back(v);
    endtask

    // Drive inputs, advance one clock, land 1 time unit after the edge.
    task automatic step(input logic [2:0] cls, input logic az, input logic rdy);
        instr_class = cls; alu_zero = az; mem_ready = rdy;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; instr_class = 3'd0; alu_zero = 1'b0; mem_ready = 1'b0;

        //  cls   az    rdy   state ctl     cyc inst
        add(3'd0, 1'b0, 1'b1, 3'd7, C_NONE,  0, 0);  // INIT
        add(3'd0, 1'b0, 1'b1, 3'd0, C_IF,    0, 0);  // ALU_R #1
        add(3'd0, 1'b0, 1'b0, 3'd1, C_NONE,  1, 0);
        add(3'd7, 1'b1, 1'b0, 3'd2, C_NONE,  2, 0);  // alu_zero must not drive PC for ALU
        add(3'd7, 1'b0, 1'b0, 3'd4, C_WBA,   3, 0);
        add(3'd0, 1'b0, 1'b1, 3'd0, C_IF,    4, 1);  // ALU_R #2
        add(3'd0, 1'b0, 1'b1, 3'd1, C_NONE,  5, 1);
        add(3'd0, 1'b0, 1'b1, 3'd2, C_NONE,  6, 1);
        add(3'd0, 1'b0, 1'b1, 3'd4, C_WBA,   7, 1);
        add(3'd0, 1'b0, 1'b1, 3'd0, C_IF,    8, 2);  // ALU_R #3
        add(3'd0, 1'b0, 1'b1, 3'd1, C_NONE,  9, 2);
        add(3'd0, 1'b0, 1'b1, 3'd2, C_NONE, 10, 2);
        add(3'd0, 1'b0, 1'b1, 3'd4, C_WBA,  11, 2);
        add(3'd0, 1'b0, 1'b1, 3'd0, C_IF,   12, 3);  // LOAD, 3 wait states
        add(3'd2, 1'b0, 1'b0, 3'd1, C_NONE, 13, 3);
        add(3'd3, 1'b0, 1'b0, 3'd2, C_NONE, 14, 3);  // class change after ID ignored
        add(3'd3, 1'b0, 1'b0, 3'd3, C_MRD,  15, 3);
        add(3'd3, 1'b0, 1'b0, 3'd3, C_MRD,  16, 3);
        add(3'd3, 1'b0, 1'b0, 3'd3, C_MRD,  17, 3);
        add(3'd3, 1'b0, 1'b1, 3'd3, C_MRD,  18, 3);
        add(3'd3, 1'b0, 1'b0, 3'd4, C_WBL,  19, 3);
        add(3'd0, 1'b0, 1'b1, 3'd0, C_IF,   20, 4);  // BRANCH taken
        add(3'd4, 1'b0, 1'b1, 3'd1, C_NONE, 21, 4);
        add(3'd4, 1'b1, 1'b1, 3'd2, C_BRT,  22, 4);
        add(3'd0, 1'b0, 1'b1, 3'd0, C_IF,   23, 5);  // BRANCH not taken
        add(3'd4, 1'b1, 1'b1, 3'd1, C_NONE, 24, 5);
        add(3'd4, 1'b0, 1'b1, 3'd2, C_BRN,  25, 5);
        add(3'd0, 1'b0, 1'b1, 3'd0, C_IF,   26, 6);  // JUMP
        add(3'd5, 1'b0, 1'b1, 3'd1, C_JMP,  27, 6);
        add(3'd0, 1'b0, 1'b0, 3'd0, C_IFS,  28, 7);  // IF stall
        add(3'd0, 1'b0, 1'b1, 3'd0, C_IF,   29, 7);  // STORE
        add(3'd3, 1'b0, 1'b1, 3'd1, C_NONE, 30, 7);
        add(3'd3, 1'b0, 1'b1, 3'd2, C_NONE, 31, 7);
        add(3'd3, 1'b0, 1'b1, 3'd3, C_MWR,  32, 7);
        add(3'd0, 1'b0, 1'b0, 3'd0, C_IFS,  33, 8);

        #7;
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            instr_class = vecs[i].cls;
            alu_zero    = vecs[i].az;
            mem_ready   = vecs[i].rdy;
            #2;
            chk($sformatf("vec%0d state", i), {29'd0, state}, {29'd0, vecs[i].st});
            chk($sformatf("vec%0d ctl", i), {21'd0, ctl_now()}, {21'd0, vecs[i].ctl});
            chk($sformatf("vec%0d cycle_cnt", i), cycle_cnt, vecs[i].cyc);
            chk($sformatf("vec%0d instr_cnt", i), instr_cnt, vecs[i].inst);
            @(posedge clk); #1;
        end

        // Illegal class in ID: sticky flag, HALT holds, counters frozen.
        do_reset();
        step(3'd0, 1'b0, 1'b1);   // INIT -> IF
        step(3'd0, 1'b0, 1'b1);   // IF -> ID
        step(3'd7, 1'b0, 1'b1);   // ID -> HALT
        chk("ill state", {29'd0, state}, 32'd5);
        chk("ill flags", {30'd0, illegal, halted}, 32'd3);
        for (int k = 0; k < 20; k++) begin
            step(3'(k), k[0], k[1]);
            chk($sformatf("halt%0d state", k), {29'd0, state}, 32'd5);
            chk($sformatf("halt%0d ctl", k), {21'd0, ctl_now()}, 32'h3);
            chk($sformatf("halt%0d cnt", k), cycle_cnt + (instr_cnt << 16), 32'd2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("ill rst state", {29'd0, state}, 32'd7);
        chk("ill rst ctl", {21'd0, ctl_now()}, 32'd0);
        chk("ill rst cnt", cycle_cnt | instr_cnt, 32'd0);
        #3;
        rst_n = 1'b1;

        // HALT class: halts without flagging illegal.
        do_reset();
        step(3'd6, 1'b0, 1'b1);
        step(3'd6, 1'b0, 1'b1);
        step(3'd6, 1'b0, 1'b1);
        step(3'd0, 1'b0, 1'b1);
        chk("halt6 state", {29'd0, state}, 32'd5);
        chk("halt6 flags", {30'd0, illegal, halted}, 32'd1);
        chk("halt6 instr_cnt", instr_cnt, 32'd0);

        // Asynchronous reset during STORE memory wait.
        do_reset();
        step(3'd0, 1'b0, 1'b1);   // INIT -> IF
        step(3'd0, 1'b0, 1'b1);   // IF -> ID
        step(3'd3, 1'b0, 1'b1);   // ID -> EX
        step(3'd0, 1'b0, 1'b0);   // EX -> MEM
        step(3'd0, 1'b0, 1'b0);   // MEM stall
        chk("st wait state", {29'd0, state}, 32'd3);
        chk("st wait ctl", {21'd0, ctl_now()}, {21'd0, C_MWR});
        chk("st wait cycle_cnt", cycle_cnt, 32'd4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("st rst mem_write", {31'd0, mem_write}, 32'd0);
        chk("st rst ctl", {21'd0, ctl_now()}, 32'd0);
        chk("st rst state", {29'd0, state}, 32'd7);
        chk("st rst cnt", cycle_cnt | instr_cnt, 32'd0);
        #3;
        rst_n = 1'b1;
        #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
